fifo_wr_ctrl: RTL and testbench

//  Write-side controller of the async FIFO; runs entirely in the write clock domain.

---
 rtl/fifo_pkg.sv | 27 ++
 rtl/fifo_wr_ctrl_if.sv | 35 +++
 rtl/fifo_sync_2ff.sv | 29 ++
 rtl/fifo_wr_ctrl.sv | 80 ++++++++
 tb/tb_fifo_wr_ctrl.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared Gray/binary helpers and geometry checks for the async FIFO
package fifo_pkg;

    // Helpers work on a 32-bit container; callers zero-extend narrower pointers
    // and truncate the result, which keeps them usable for any pointer width.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return (b >> 1) ^ b;
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = g;
        for (int i = 1; i < 32; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

    function automatic bit depth_ok(input int p_size, input int depth);
        return (p_size >= 3) && (depth == (1 << (p_size - 1)));
    endfunction

    function automatic bit af_level_ok(input int af_level, input int depth);
        return (af_level >= 1) && (af_level <= depth);
    endfunction

endpackage

// File: rtl/fifo_wr_ctrl_if.sv
// rtl/fifo_wr_ctrl_if.sv - write-side producer/flag bundle of the async FIFO
interface fifo_wr_ctrl_if #(
    parameter int P_SIZE = 4
) ();
    logic              w_inc;
    logic [P_SIZE-1:0] r_gptr;
    logic [P_SIZE-2:0] w_addr;
    logic [P_SIZE-1:0] w_gptr;
    logic              w_full;
    logic              w_almost_full;
    logic [P_SIZE-1:0] w_count;
    logic              w_overflow;

    modport master (
        output w_inc,
        output r_gptr,
        input  w_addr,
        input  w_gptr,
        input  w_full,
        input  w_almost_full,
        input  w_count,
        input  w_overflow
    );

    modport slave (
        input  w_inc,
        input  r_gptr,
        output w_addr,
        output w_gptr,
        output w_full,
        output w_almost_full,
        output w_count,
        output w_overflow
    );
endinterface

// File: rtl/fifo_sync_2ff.sv
// rtl/fifo_sync_2ff.sv - two-flop synchroniser for Gray-coded pointers crossing clock domains
module fifo_sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;
endmodule

// File: rtl/fifo_wr_ctrl.sv
// rtl/fifo_wr_ctrl.sv - async FIFO write controller: pointers, read-pointer sync, full/count flags
module fifo_wr_ctrl
    import fifo_pkg::*;
#(
    parameter int P_SIZE   = 4,
    parameter int F_DEPTH  = 8,
    parameter int AF_LEVEL = 6
) (
    input  logic           w_clk,
    input  logic           w_rst,
    fifo_wr_ctrl_if.slave  wif
);
    if (!depth_ok(P_SIZE, F_DEPTH)) begin : g_bad_depth
        $error("fifo_wr_ctrl: F_DEPTH must equal 2**(P_SIZE-1)");
    end
    if (!af_level_ok(AF_LEVEL, F_DEPTH)) begin : g_bad_af
        $error("fifo_wr_ctrl: AF_LEVEL must lie in 1..F_DEPTH");
    end

    logic [P_SIZE-1:0] wbin_q, wbin_d;
    logic [P_SIZE-1:0] wgray_q, wgray_d;
    logic [P_SIZE-1:0] count_q, count_d;
    logic              full_q, full_d;
    logic              af_q, af_d;
    logic              ovf_q, ovf_d;
    logic [P_SIZE-1:0] rq2_gptr;
    logic [P_SIZE-1:0] rbin;
    logic [P_SIZE-1:0] level_next;
    logic [P_SIZE-1:0] full_gray;
    logic              wr_en;

    fifo_sync_2ff #(
        .WIDTH (P_SIZE)
    ) u_rptr_sync (
        .clk (w_clk),
        .rst (w_rst),
        .d   (wif.r_gptr),
        .q   (rq2_gptr)
    );

    // Flags are evaluated from the next write pointer so that the write filling
    // the last slot raises w_full on the very next cycle.
    always_comb begin
        wr_en      = wif.w_inc & ~full_q;
        wbin_d     = wbin_q + P_SIZE'(wr_en);
        wgray_d    = P_SIZE'(bin2gray(32'(wbin_d)));
        rbin       = P_SIZE'(gray2bin(32'(rq2_gptr)));
        level_next = wbin_d - rbin;
        full_gray  = {~rq2_gptr[P_SIZE-1:P_SIZE-2], rq2_gptr[P_SIZE-3:0]};
        full_d     = (wgray_d == full_gray);
        count_d    = level_next;
        af_d       = (int'(level_next) >= AF_LEVEL);
        ovf_d      = wif.w_inc & full_q;
    end

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            af_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
            count_q <= count_d;
            full_q  <= full_d;
            af_q    <= af_d;
            ovf_q   <= ovf_d;
        end
    end

    assign wif.w_addr        = wbin_q[P_SIZE-2:0];
    assign wif.w_gptr        = wgray_q;
    assign wif.w_full        = full_q;
    assign wif.w_almost_full = af_q;
    assign wif.w_count       = count_q;
    assign wif.w_overflow    = ovf_q;
endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// tb/tb_fifo_wr_ctrl.sv - self-checking bench for fifo_wr_ctrl against a write/read counting model
module tb_fifo_wr_ctrl;
    import fifo_pkg::*;

    localparam int P  = 4;
    localparam int D  = 8;
    localparam int AF = 6;

    logic w_clk = 1'b0;
    logic w_rst = 1'b1;

    fifo_wr_ctrl_if #(.P_SIZE(P)) wif ();

    fifo_wr_ctrl #(
        .P_SIZE   (P),
        .F_DEPTH  (D),
        .AF_LEVEL (AF)
    ) dut (
        .w_clk (w_clk),
        .w_rst (w_rst),
        .wif   (wif)
    );

    always #5 w_clk = ~w_clk;

    int n_chk  = 0;
    int n_fail = 0;
    int rd_total = 0;

    // Model: total accepted writes, read totals as seen after the two-edge sync delay.
    int m_wr, m_s1, m_s2, m_level;
    bit m_full, m_ovf;
    logic [P-1:0] prev_gptr;
    bit prev_valid;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_wr = 0; m_s1 = 0; m_s2 = 0; m_level = 0;
        m_full = 0; m_ovf = 0; prev_valid = 0;
    endtask

    initial begin
        logic [P-1:0] g_exp;
        model_reset();
        forever begin
            @(posedge w_clk);
            if (w_rst) begin
                model_reset();
            end else begin
                m_ovf = wif.w_inc && m_full;
                if (wif.w_inc && !m_full) m_wr++;
                m_level = m_wr - m_s2;
                m_s2 = m_s1;
                m_s1 = rd_total;
                m_full = (m_level == D);
            end
            @(negedge w_clk);
            if (w_rst) model_reset();
            g_exp = P'(bin2gray(32'(m_wr % (2 * D))));
            chk("w_addr",        int'(wif.w_addr),   m_wr % D);
            chk("w_gptr",        int'(wif.w_gptr),   int'(g_exp));
            chk("w_full",        int'(wif.w_full),   int'(m_full));
            chk("w_almost_full", int'(wif.w_almost_full), int'(m_level >= AF));
            chk("w_count",       int'(wif.w_count),  m_level);
            chk("w_overflow",    int'(wif.w_overflow), int'(m_ovf));
            if (prev_valid) chk("gptr_single_bit_step", int'($countones(prev_gptr ^ wif.w_gptr) <= 1), 1);
            prev_gptr  = wif.w_gptr;
            prev_valid = !w_rst;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic step(input bit inc, input bit adv);
        @(posedge w_clk);
        #1;
        wif.w_inc = inc;
        if (adv) rd_total++;
        wif.r_gptr = P'(bin2gray(32'(rd_total % (2 * D))));
    endtask

    initial begin
        int seen;
        bit inc, adv;
        wif.w_inc  = 1'b0;
        wif.r_gptr = '0;

        // Reset state and asynchronous reset in the middle of a write burst
        repeat (3) @(posedge w_clk);
        #1;
        chk("rst_count", int'(wif.w_count), 0);
        chk("rst_full",  int'(wif.w_full),  0);
        w_rst = 1'b0;
        repeat (4) step(1, 0);
        chk("burst_addr_before_rst", int'(wif.w_addr), 3);
        #2 w_rst = 1'b1;
        #1;
        chk("async_rst_addr",  int'(wif.w_addr),  0);
        chk("async_rst_gptr",  int'(wif.w_gptr),  0);
        chk("async_rst_count", int'(wif.w_count), 0);
        wif.w_inc = 1'b0;
        rd_total = 0;
        wif.r_gptr = '0;
        repeat (2) @(posedge w_clk);
        #1 w_rst = 1'b0;
        chk("addr_after_release", int'(wif.w_addr), 0);

        // Fill with the read pointer parked at zero
        for (int j = 1; j <= 9; j++) begin
            step(j <= 8, 0);
            if (j == 6) chk("af_after5", int'(wif.w_almost_full), 0);
            if (j == 7) chk("af_after6", int'(wif.w_almost_full), 1);
            if (j == 8) chk("full_after7", int'(wif.w_full), 0);
        end
        chk("fill_full",  int'(wif.w_full),  1);
        chk("fill_count", int'(wif.w_count), 8);
        chk("fill_gptr",  int'(wif.w_gptr),  12);
        chk("fill_addr",  int'(wif.w_addr),  0);

        // Overflow while full
        seen = 0;
        for (int j = 0; j < 6; j++) begin
            step(j < 3, 0);
            seen += int'(wif.w_overflow);
        end
        chk("ovf_cycles", seen, 3);
        chk("ovf_addr",  int'(wif.w_addr),  0);
        chk("ovf_gptr",  int'(wif.w_gptr),  12);
        chk("ovf_count", int'(wif.w_count), 8);

        // One read: w_full drops on the third edge after r_gptr moves
        step(0, 1);
        step(0, 0);
        chk("drain_full_e1", int'(wif.w_full), 1);
        step(0, 0);
        chk("drain_full_e2", int'(wif.w_full), 1);
        step(0, 0);
        chk("drain_full_e3", int'(wif.w_full), 0);
        chk("drain_count", int'(wif.w_count), 7);

        // Down to level 3, then wrap with concurrent reads
        repeat (4) step(0, 1);
        repeat (3) step(0, 0);
        chk("level3_count", int'(wif.w_count), 3);
        seen = 0;
        for (int j = 0; j < 20; j++) begin
            step(1, 1);
            seen |= int'(wif.w_full);
        end
        repeat (3) step(0, 0);
        chk("wrap_full_never", seen, 0);
        chk("wrap_count", int'(wif.w_count), 3);

        // Level 5, then a write and a synced read land on the same edge
        repeat (2) step(1, 0);
        repeat (3) step(0, 0);
        chk("level5_count", int'(wif.w_count), 5);
        step(0, 1);
        step(0, 0);
        step(1, 0);
        chk("simul_count_pre", int'(wif.w_count), 5);
        step(0, 0);
        chk("simul_count", int'(wif.w_count), 5);
        chk("simul_af",    int'(wif.w_almost_full), 0);
        step(0, 0);
        chk("simul_count_post", int'(wif.w_count), 5);

        // Randomised traffic with one reset part way through
        for (int i = 0; i < 1500; i++) begin
            if (i == 1000) begin
                @(posedge w_clk);
                #3 w_rst = 1'b1;
                wif.w_inc = 1'b0;
                rd_total = 0;
                wif.r_gptr = '0;
                step(0, 0);
                step(0, 0);
                w_rst = 1'b0;
            end
            if ((i % 500) < 250) begin
                inc = ($urandom_range(0, 3) != 0);
                adv = ($urandom_range(0, 3) == 0);
            end else begin
                inc = ($urandom_range(0, 3) == 0);
                adv = ($urandom_range(0, 3) != 0);
            end
            step(inc, adv && (rd_total < m_wr));
        end
        repeat (4) step(0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
